// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule. Streams round keys 0..10 over a
// valid/ready handshake and keeps every round key in an 11-entry key
// file so the decrypt path can read the schedule back in any order.

// Byte S-box computed as GF(2^8) multiplicative inverse followed by the
// AES affine transform; purely combinational.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Full GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0, which is what the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // AES affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    // Substitute one byte.
    always_comb begin
        out_o = affine(gf_inv(in_i));
    end

endmodule

module aes128_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_IDX = NUM_ROUNDS[3:0];

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Round constant looked up from the round number (1..10).
    function automatic logic [7:0] rcon_lut(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t         state_q;
    logic           key_ready_q;
    logic           rk_valid_q;
    logic [127:0]   round_key_q;
    logic [3:0]     rk_idx_q;
    logic           keys_valid_q;
    logic [127:0]   key_file_q [0:10];

    logic [31:0]    w0_s, w1_s, w2_s, w3_s;
    logic [31:0]    rot_s;
    logic [31:0]    sub_s;
    logic [31:0]    temp_s;
    logic [31:0]    n0_s, n1_s, n2_s, n3_s;
    logic [127:0]   next_key_d;
    logic [3:0]     next_idx_d;
    logic           xfer_s;

    assign w0_s  = round_key_q[127:96];
    assign w1_s  = round_key_q[95:64];
    assign w2_s  = round_key_q[63:32];
    assign w3_s  = round_key_q[31:0];
    assign rot_s = {w3_s[23:0], w3_s[31:24]};

    aes_sbox u_sbox0 (.in_i(rot_s[31:24]), .out_o(sub_s[31:24]));
    aes_sbox u_sbox1 (.in_i(rot_s[23:16]), .out_o(sub_s[23:16]));
    aes_sbox u_sbox2 (.in_i(rot_s[15:8]),  .out_o(sub_s[15:8]));
    aes_sbox u_sbox3 (.in_i(rot_s[7:0]),   .out_o(sub_s[7:0]));

    // One key-schedule step: words chained within the same cycle.
    always_comb begin
        next_idx_d = rk_idx_q + 4'd1;
        temp_s     = sub_s ^ {rcon_lut(next_idx_d), 24'h000000};
        n0_s       = w0_s ^ temp_s;
        n1_s       = w1_s ^ n0_s;
        n2_s       = w2_s ^ n1_s;
        n3_s       = w3_s ^ n2_s;
        next_key_d = {n0_s, n1_s, n2_s, n3_s};
    end

    assign xfer_s = rk_valid_q & rk_ready;

    // Handshake FSM: loads the cipher key, advances on each transfer,
    // fills the key file and drives all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            key_ready_q  <= 1'b1;
            rk_valid_q   <= 1'b0;
            round_key_q  <= 128'h0;
            rk_idx_q     <= 4'd0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                key_file_q[i] <= 128'h0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        round_key_q   <= key_in;
                        key_file_q[0] <= key_in;
                        rk_idx_q      <= 4'd0;
                        rk_valid_q    <= 1'b1;
                        keys_valid_q  <= 1'b0;
                        key_ready_q   <= 1'b0;
                        state_q       <= ST_STREAM;
                    end else begin
                        key_ready_q   <= 1'b1;
                        rk_valid_q    <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (xfer_s && (rk_idx_q == LAST_IDX)) begin
                        rk_valid_q   <= 1'b0;
                        keys_valid_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (xfer_s) begin
                        round_key_q            <= next_key_d;
                        rk_idx_q               <= next_idx_d;
                        key_file_q[next_idx_d] <= next_key_d;
                    end else begin
                        // Stalled: hold key, index and valid steady.
                        rk_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    key_ready_q <= 1'b1;
                    rk_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse coincides with the transfer of the last round key.
    always_comb begin
        if ((state_q == ST_STREAM) && xfer_s && (rk_idx_q == LAST_IDX)) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
    end

    // Random-access readback; out-of-range indices read as zero.
    always_comb begin
        rd_key = 128'h0;
        if (rd_idx <= LAST_IDX) begin
            rd_key = key_file_q[rd_idx];
        end else begin
            rd_key = 128'h0;
        end
    end

    assign key_ready  = key_ready_q;
    assign rk_valid   = rk_valid_q;
    assign round_key  = round_key_q;
    assign rk_idx     = rk_idx_q;
    assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand: FIPS-197 and all-zero key schedules,
// backpressure, key_valid during streaming, readback and mid-stream reset.
module tb_aes128_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [0:13];
    logic [127:0] got  [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    aes128_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .round_key  (round_key),
        .rk_idx     (rk_idx),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare captured stream against every table entry for this key.
    task automatic check_table(input logic [127:0] key, input string tag);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].key == key) begin
                chk($sformatf("%s rk%0d", tag, vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
            end
        end
    endtask

    // Accept key, stream all 11 round keys. bp randomises rk_ready;
    // hold_other keeps key_valid high with other_key during the stream.
    task automatic run_key(input logic [127:0] key, input bit bp,
                           input bit hold_other, input logic [127:0] other_key);
        int          expect_idx;
        int          guard;
        int          cycles;
        bit          r;
        bit          stalled;
        logic [127:0] prev_key;
        for (int i = 0; i < 11; i++) got[i] = 128'hx;
        chk("key_ready before accept", {127'h0, key_ready}, 128'h1);
        key_valid = 1'b1;
        key_in    = key;
        rk_ready  = 1'b0;
        @(posedge clk); #1;
        key_valid  = hold_other;
        key_in     = hold_other ? other_key : key;
        expect_idx = 0;
        guard      = 0;
        cycles     = 0;
        stalled    = 1'b0;
        prev_key   = 128'h0;
        chk("keys_valid cleared on accept", {127'h0, keys_valid}, 128'h0);
        while (expect_idx < 11 && guard < 300) begin
            r = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            rk_ready = r;
            #1;
            cycles++;
            chk("rk_valid in stream", {127'h0, rk_valid}, 128'h1);
            chk("rk_idx order", {124'h0, rk_idx}, 128'(expect_idx));
            chk("key_ready in stream", {127'h0, key_ready}, 128'h0);
            if (stalled) chk("round_key stable in stall", round_key, prev_key);
            chk("done only on idx10 xfer", {127'h0, done}, 128'((r && expect_idx == 10) ? 1 : 0));
            if (r) begin
                got[expect_idx] = round_key;
                expect_idx++;
            end
            stalled  = !r;
            prev_key = round_key;
            guard++;
            @(posedge clk); #1;
        end
        rk_ready = 1'b0;
        if (guard >= 300) chk("stream timeout", 128'(guard), 128'(0));
        if (!bp) chk("idx10 latency cycles", 128'(cycles), 128'(11));
        #1;
        chk("rk_valid after done", {127'h0, rk_valid}, 128'h0);
        chk("keys_valid after done", {127'h0, keys_valid}, 128'h1);
        chk("key_ready after done", {127'h0, key_ready}, 128'h1);
        chk("done idle", {127'h0, done}, 128'h0);
        if (hold_other) begin
            @(posedge clk); #1;
            key_valid = 1'b0;
            chk("second key keys_valid drop", {127'h0, keys_valid}, 128'h0);
            chk("second key loaded", round_key, other_key);
            chk("second key idx0", {124'h0, rk_idx}, 128'h0);
            chk("second key rk_valid", {127'h0, rk_valid}, 128'h1);
        end
    endtask

    initial begin
        vecs[0]  = '{FIPS_KEY, 0,  FIPS_KEY};
        vecs[1]  = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{FIPS_KEY, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{FIPS_KEY, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{FIPS_KEY, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{FIPS_KEY, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{FIPS_KEY, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{FIPS_KEY, 8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[11] = '{ZERO_KEY, 0,  128'h0};
        vecs[12] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
        vecs[13] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = 128'h0;
        rk_ready  = 1'b0;
        rd_idx    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset key_ready", {127'h0, key_ready}, 128'h1);
        chk("reset rk_valid", {127'h0, rk_valid}, 128'h0);
        chk("reset round_key", round_key, 128'h0);
        chk("reset rk_idx", {124'h0, rk_idx}, 128'h0);
        chk("reset done", {127'h0, done}, 128'h0);
        chk("reset keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("reset rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 key, no backpressure
        run_key(FIPS_KEY, 1'b0, 1'b0, 128'h0);
        check_table(FIPS_KEY, "fips");

        // Readback
        rd_idx = 4'd10; #1; chk("rd idx10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd0;  #1; chk("rd idx0", rd_key, FIPS_KEY);
        rd_idx = 4'd5;  #1; chk("rd idx5", rd_key, 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        rd_idx = 4'd13; #1; chk("rd idx13", rd_key, 128'h0);
        rd_idx = 4'd15; #1; chk("rd idx15", rd_key, 128'h0);
        @(posedge clk); #1;

        // Backpressure
        run_key(FIPS_KEY, 1'b1, 1'b0, 128'h0);
        check_table(FIPS_KEY, "fips bp");
        @(posedge clk); #1;

        // Reset mid-expansion after rk_idx 4
        key_valid = 1'b1;
        key_in    = FIPS_KEY;
        @(posedge clk); #1;
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        for (int g = 0; g < 20 && rk_idx != 4'd4; g++) begin
            @(posedge clk); #1;
        end
        chk("reached idx4", {124'h0, rk_idx}, 128'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst rk_valid", {127'h0, rk_valid}, 128'h0);
        chk("async rst round_key", round_key, 128'h0);
        chk("async rst rk_idx", {124'h0, rk_idx}, 128'h0);
        chk("async rst keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("async rst key_ready", {127'h0, key_ready}, 128'h1);
        chk("async rst done", {127'h0, done}, 128'h0);
        rd_idx = 4'd10; #1;
        chk("async rst key file", rd_key, 128'h0);
        rk_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_key(FIPS_KEY, 1'b0, 1'b0, 128'h0);
        check_table(FIPS_KEY, "fips post-rst");

        // All-zero key
        @(posedge clk); #1;
        run_key(ZERO_KEY, 1'b0, 1'b0, 128'h0);
        check_table(ZERO_KEY, "zero");

        // key_valid held high with another key during streaming
        @(posedge clk); #1;
        run_key(FIPS_KEY, 1'b0, 1'b1, ALT_KEY);
        check_table(FIPS_KEY, "fips hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
